// File: rtl/cell_update_sequencer_if.sv
// Handshake and bus signals between the cell update sequencer, the game
// logic that supplies object flags, and the draw engine that consumes
// draw commands.
interface cell_update_sequencer_if;
    logic       frame_start;
    logic       full_redraw;
    logic       border;
    logic       snakeHead;
    logic       snakeBody;
    logic       apple;
    logic       cmd_done;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj_code;
    logic       cmd_valid;
    logic       busy;
    logic       frame_done;

    modport master (
        input  frame_start, full_redraw, border, snakeHead, snakeBody, apple, cmd_done,
        output x, y, obj_code, cmd_valid, busy, frame_done
    );

    modport slave (
        output frame_start, full_redraw, border, snakeHead, snakeBody, apple, cmd_done,
        input  x, y, obj_code, cmd_valid, busy, frame_done
    );
endinterface

// File: rtl/cell_update_sequencer.sv
// Cell update sequencer: scans a 16x12 grid once per frame request, compares
// each cell's object code against a frame buffer of what was last drawn, and
// issues a draw command (held until cmd_done) for every cell that changed or
// for every cell when a full redraw is active.
module cell_update_sequencer (
    input  logic                    clk,
    input  logic                    nrst,
    cell_update_sequencer_if.master bus
);
    localparam logic [3:0] X_LAST  = 4'd15;
    localparam logic [3:0] Y_LAST  = 4'd11;
    localparam logic [2:0] C_EMPTY  = 3'd0;
    localparam logic [2:0] C_BODY   = 3'd1;
    localparam logic [2:0] C_HEAD   = 3'd2;
    localparam logic [2:0] C_APPLE  = 3'd3;
    localparam logic [2:0] C_BORDER = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic [2:0] r_obj_code;
    logic [2:0] r_buf [0:15][0:11];
    logic       r_redraw_pending;
    logic       r_redraw_active;

    logic [2:0] w_code;
    logic       w_diff;
    logic       w_last;
    logic       w_accept;
    logic       w_advance;
    logic       w_busy;
    logic       w_frame_done;
    logic       w_cmd_valid;

    // Object priority: border hides everything, head hides body, body hides apple.
    function automatic logic [2:0] f_encode(input logic i_border, input logic i_head,
                                            input logic i_body, input logic i_apple);
        if (i_border)    return C_BORDER;
        else if (i_head) return C_HEAD;
        else if (i_body) return C_BODY;
        else if (i_apple) return C_APPLE;
        else             return C_EMPTY;
    endfunction

    assign w_code    = f_encode(bus.border, bus.snakeHead, bus.snakeBody, bus.apple);
    assign w_diff    = (w_code != r_buf[r_x][r_y]) || r_redraw_active;
    assign w_last    = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_accept  = (r_state == S_IDLE) && bus.frame_start;
    assign w_advance = ((r_state == S_SCAN) && !w_diff) ||
                       ((r_state == S_WAIT) && bus.cmd_done);

    // State register; reset abandons any outstanding command.
    always_ff @(posedge clk) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; frame_start outside IDLE and cmd_done outside WAIT fall through unused.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.frame_start) w_next = S_SCAN;
            S_SCAN: begin
                if (w_diff)      w_next = S_WAIT;
                else if (w_last) w_next = S_DONE;
            end
            S_WAIT: if (bus.cmd_done) w_next = w_last ? S_DONE : S_SCAN;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state; cmd_valid is exactly "in WAIT".
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_frame_done = (r_state == S_DONE);
        w_cmd_valid  = (r_state == S_WAIT);
    end

    // Cell counter: x runs fastest, wraps to (0,0) after the last cell and outside a scan.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_x <= 4'd0;
            r_y <= 4'd0;
        end else if (w_advance) begin
            if (w_last) begin
                r_x <= 4'd0;
                r_y <= 4'd0;
            end else if (r_x == X_LAST) begin
                r_x <= 4'd0;
                r_y <= r_y + 4'd1;
            end else begin
                r_x <= r_x + 4'd1;
            end
        end else if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
            r_x <= 4'd0;
            r_y <= 4'd0;
        end
    end

    // Frame buffer and command code, both captured on the cycle a command is issued.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_obj_code <= C_EMPTY;
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 12; j++) begin
                    r_buf[i][j] <= C_EMPTY;
                end
            end
        end else if ((r_state == S_SCAN) && w_diff) begin
            r_buf[r_x][r_y] <= w_code;
            r_obj_code      <= w_code;
        end
    end

    // Redraw requests are latched at any time but only take effect at the start of a frame.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_redraw_pending <= 1'b1;
            r_redraw_active  <= 1'b0;
        end else if (w_accept) begin
            r_redraw_active  <= r_redraw_pending | bus.full_redraw;
            r_redraw_pending <= 1'b0;
        end else begin
            if (bus.full_redraw)     r_redraw_pending <= 1'b1;
            if (r_state == S_DONE)   r_redraw_active  <= 1'b0;
        end
    end

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.obj_code   = r_obj_code;
    assign bus.cmd_valid  = w_cmd_valid;
    assign bus.busy       = w_busy;
    assign bus.frame_done = w_frame_done;
endmodule

// File: tb/tb_cell_update_sequencer.sv
// Testbench for cell_update_sequencer: drives object maps and frame requests,
// plays the draw engine, and compares the issued command stream and frame
// timing against a frame-level reference model.
module tb_cell_update_sequencer;
    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    cell_update_sequencer_if bus();

    cell_update_sequencer dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // Object maps indexed by y*16+x, read combinationally at the DUT's current cell.
    logic [191:0] m_border;
    logic [191:0] m_head;
    logic [191:0] m_body;
    logic [191:0] m_apple;

    assign bus.border    = m_border[{bus.y, bus.x}];
    assign bus.snakeHead = m_head[{bus.y, bus.x}];
    assign bus.snakeBody = m_body[{bus.y, bus.x}];
    assign bus.apple     = m_apple[{bus.y, bus.x}];

    int         n_checks  = 0;
    int         n_pass    = 0;
    logic [2:0] mbuf [192];
    bit         m_pending = 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [7:0] idx(input int x, input int y);
        return 8'(y * 16 + x);
    endfunction

    function automatic logic [2:0] cell_code(input logic [7:0] i);
        if (m_border[i]) return 3'd4;
        if (m_head[i])   return 3'd2;
        if (m_body[i])   return 3'd1;
        if (m_apple[i])  return 3'd3;
        return 3'd0;
    endfunction

    task automatic clear_map();
        m_border = '0;
        m_head   = '0;
        m_body   = '0;
        m_apple  = '0;
    endtask

    task automatic border_map();
        clear_map();
        for (int i = 0; i < 192; i++) begin
            m_border[8'(i)] = ((i % 16) == 0) || ((i % 16) == 15) || ((i / 16) == 0) || ((i / 16) == 11);
        end
    endtask

    task automatic random_map();
        clear_map();
        for (int i = 0; i < 192; i++) begin
            bit edge_cell;
            edge_cell = ((i % 16) == 0) || ((i % 16) == 15) || ((i / 16) == 0) || ((i / 16) == 11);
            m_border[8'(i)] = edge_cell && ($urandom_range(0, 7) != 0);
            m_head[8'(i)]   = ($urandom_range(0, 23) == 0);
            m_body[8'(i)]   = ($urandom_range(0, 7) == 0);
            m_apple[8'(i)]  = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 192; i++) mbuf[i] = 3'd0;
        m_pending = 1'b1;
    endtask

    // One frame: h = cycles cmd_valid is held (cmd_done in the last of them),
    // rmid = full_redraw pulse mid-frame, rstart = full_redraw with frame_start,
    // fsmid = extra frame_start pulse while busy.
    task automatic run_frame(input int h, input bit rmid, input bit rstart, input bit fsmid);
        int  q[$];
        int  exp_n, got_n, exp_busy, busy_n, fd_n, fd_at, wcnt, e;
        int  lx, ly, lc;
        bit  active, ended;
        active   = m_pending | rstart;
        m_pending = 1'b0;
        for (int i = 0; i < 192; i++) begin
            logic [2:0] c;
            c = cell_code(8'(i));
            if (active || (c != mbuf[i])) q.push_back(((i / 16) << 7) | ((i % 16) << 3) | int'(c));
            mbuf[i] = c;
        end
        exp_n    = q.size();
        exp_busy = 193 + exp_n * h;
        got_n = 0; busy_n = 0; fd_n = 0; fd_at = -1; wcnt = 0; ended = 1'b0;
        lx = 0; ly = 0; lc = 0;

        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.full_redraw = rstart;
        for (int cyc = 1; cyc <= 5000 && !ended; cyc++) begin
            @(negedge clk);
            bus.frame_start = 1'b0;
            bus.full_redraw = 1'b0;
            bus.cmd_done    = 1'b0;
            if (rmid && cyc == 20)  bus.full_redraw = 1'b1;
            if (fsmid && cyc == 30) bus.frame_start = 1'b1;
            if (bus.busy) busy_n++;
            if (bus.frame_done) begin
                fd_n++;
                fd_at = busy_n;
            end
            if (bus.cmd_valid) begin
                if (wcnt == 0) begin
                    got_n++;
                    if (q.size() == 0) begin
                        chk("cmd_extra", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("cmd_x", int'(bus.x), (e >> 3) & 15);
                        chk("cmd_y", int'(bus.y), (e >> 7) & 15);
                        chk("cmd_code", int'(bus.obj_code), e & 7);
                    end
                    lx = int'(bus.x); ly = int'(bus.y); lc = int'(bus.obj_code);
                end else begin
                    chk("hold_x", int'(bus.x), lx);
                    chk("hold_y", int'(bus.y), ly);
                    chk("hold_code", int'(bus.obj_code), lc);
                end
                wcnt++;
                if (wcnt == h) bus.cmd_done = 1'b1;
            end else begin
                wcnt = 0;
            end
            if (!bus.busy) ended = 1'b1;
        end
        bus.cmd_done    = 1'b0;
        bus.frame_start = 1'b0;
        bus.full_redraw = 1'b0;
        chk("frame_ended", int'(ended), 1);
        chk("cmd_count", got_n, exp_n);
        chk("busy_cycles", busy_n, exp_busy);
        chk("frame_done_count", fd_n, 1);
        chk("frame_done_pos", fd_at, exp_busy);
        if (rmid) m_pending = 1'b1;
        @(negedge clk);
        chk("idle_after_frame", int'(bus.busy), 0);
    endtask

    initial begin
        bit found;
        nrst            = 1'b0;
        bus.frame_start = 1'b0;
        bus.full_redraw = 1'b0;
        bus.cmd_done    = 1'b0;
        clear_map();
        repeat (2) @(negedge clk);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_code", int'(bus.obj_code), 0);
        chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        nrst = 1'b1;
        model_reset();

        // First frame after reset redraws everything; the repeat draws nothing.
        border_map();
        run_frame(2, 1'b0, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0, 1'b0);

        // Map A then map B: only the two changed cells are redrawn.
        m_head[idx(4, 4)]  = 1'b1;
        m_apple[idx(7, 4)] = 1'b1;
        run_frame(1, 1'b0, 1'b0, 1'b0);
        m_head[idx(4, 4)] = 1'b0;
        m_body[idx(4, 4)] = 1'b1;
        m_head[idx(5, 4)] = 1'b1;
        run_frame(3, 1'b0, 1'b0, 1'b0);

        // Slow draw engine plus an ignored frame_start while busy.
        m_apple[idx(7, 4)] = 1'b0;
        m_apple[idx(9, 6)] = 1'b1;
        run_frame(6, 1'b0, 1'b0, 1'b1);

        // cmd_done in IDLE changes nothing.
        @(negedge clk);
        bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.cmd_done = 1'b0;
        chk("idle_done_busy", int'(bus.busy), 0);
        chk("idle_done_valid", int'(bus.cmd_valid), 0);
        chk("idle_done_x", int'(bus.x), 0);
        chk("idle_done_y", int'(bus.y), 0);

        // Mid-frame redraw request applies to the following frame only.
        m_body[idx(3, 3)] = 1'b1;
        run_frame(1, 1'b1, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0, 1'b0);

        // Redraw coincident with the accepted frame_start applies immediately.
        run_frame(1, 1'b0, 1'b1, 1'b0);

        // Randomized maps and draw-engine latencies.
        repeat (6) begin
            random_map();
            run_frame(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset held for two cycles while a command is outstanding.
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.full_redraw = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            bus.frame_start = 1'b0;
            bus.full_redraw = 1'b0;
            if (bus.cmd_valid) found = 1'b1;
        end
        bus.frame_start = 1'b0;
        bus.full_redraw = 1'b0;
        chk("wait_reached", int'(found), 1);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        chk("wrst_x", int'(bus.x), 0);
        chk("wrst_y", int'(bus.y), 0);
        chk("wrst_cmd_valid", int'(bus.cmd_valid), 0);
        chk("wrst_busy", int'(bus.busy), 0);
        chk("wrst_frame_done", int'(bus.frame_done), 0);
        model_reset();
        @(negedge clk);
        bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.cmd_done = 1'b0;
        chk("late_done_valid", int'(bus.cmd_valid), 0);
        chk("late_done_busy", int'(bus.busy), 0);
        run_frame(1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
